uart_rx: RTL and testbench

//  UART receiver (8N1, LSB first); consumes the serial line driven by uart_tx.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_rx_state_t;

   // Clock cycles per bit period (integer division, truncating).
   function automatic int clks_per_bit(input int fclk, input int baud);
      return fclk / baud;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_reg;

   // Shift the raw input through two flops; the second flop feeds the fabric.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_reg <= {2{RESET_VAL}};
      end else begin
         sync_reg <= {sync_reg[0], d_i};
      end
   end

   assign q_o = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling.
// Optional even-parity (8E1) frame when UART_RX_PARITY_EN is defined.
module uart_rx
   import uart_pkg::*;
#(
   parameter int FCLK = 50000000,
   parameter int BAUD = 115200
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       rx_valid_o,
   output logic       frame_err_o,
   output logic       parity_err_o,
   output logic       idle_o
);

   localparam int CPB = clks_per_bit(FCLK, BAUD);
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

   logic rx_s;

   uart_rx_state_t state_reg, state_next;
   logic [CW-1:0]  clk_cnt_reg, clk_cnt_next;
   logic [2:0]     bit_cnt_reg, bit_cnt_next;
   logic [7:0]     sr_reg, sr_next;
   logic [7:0]     data_reg, data_next;
   logic           valid_reg, valid_next;
   logic           ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
   logic           perr_reg, perr_next;
   logic           par_bad_reg, par_bad_next;
`endif

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (rx_i),
      .q_o     (rx_s)
   );

   // Next-state and datapath decode for the frame FSM.
   always_comb begin
      state_next   = state_reg;
      clk_cnt_next = clk_cnt_reg + CW'(1);
      bit_cnt_next = bit_cnt_reg;
      sr_next      = sr_reg;
      data_next    = data_reg;
      valid_next   = 1'b0;
      ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_next    = 1'b0;
      par_bad_next = par_bad_reg;
`endif
      case (state_reg)
         IDLE: begin
            clk_cnt_next = '0;
            if (!rx_s) begin
               state_next = START;
            end
         end
         START: begin
            // Re-check the start bit at its centre to reject short glitches.
            if (clk_cnt_reg == CNT_HALF) begin
               clk_cnt_next = '0;
               bit_cnt_next = '0;
               state_next   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (clk_cnt_reg == CNT_FULL) begin
               clk_cnt_next = '0;
               sr_next      = {rx_s, sr_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            // Even parity: data bits plus parity bit must XOR to zero.
            if (clk_cnt_reg == CNT_FULL) begin
               clk_cnt_next = '0;
               par_bad_next = rx_s ^ (^sr_reg);
               state_next   = STOP;
            end
         end
`endif
         STOP: begin
            // Leave at mid-stop-bit so a start bit right after is not missed.
            if (clk_cnt_reg == CNT_FULL) begin
               clk_cnt_next = '0;
               if (!rx_s) begin
                  ferr_next  = 1'b1;
                  state_next = BREAK;
               end else begin
                  state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad_reg) begin
                     perr_next = 1'b1;
                  end else begin
                     data_next  = sr_reg;
                     valid_next = 1'b1;
                  end
`else
                  data_next  = sr_reg;
                  valid_next = 1'b1;
`endif
               end
            end
         end
         BREAK: begin
            // Line held low after a bad stop bit: wait for it to return high.
            clk_cnt_next = '0;
            if (rx_s) begin
               state_next = IDLE;
            end
         end
         default: begin
            clk_cnt_next = '0;
            state_next   = IDLE;
         end
      endcase
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg   <= IDLE;
         clk_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         sr_reg      <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         ferr_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_reg    <= 1'b0;
         par_bad_reg <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         clk_cnt_reg <= clk_cnt_next;
         bit_cnt_reg <= bit_cnt_next;
         sr_reg      <= sr_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         ferr_reg    <= ferr_next;
`ifdef UART_RX_PARITY_EN
         perr_reg    <= perr_next;
         par_bad_reg <= par_bad_next;
`endif
      end
   end

   assign data_o      = data_reg;
   assign rx_valid_o  = valid_reg;
   assign frame_err_o = ferr_reg;
   assign idle_o      = (state_reg == IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err_o = perr_reg;
`else
   assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged frames on rx_i, pulses monitored at negedge.
module tb_uart_rx;

   localparam int CPB = 50000000 / 115200;   // 434
`ifdef UART_RX_PARITY_EN
   localparam int EXP_LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
   localparam int EXP_LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n_i;
   logic       rx_i;
   logic [7:0] data_o;
   logic       rx_valid_o;
   logic       frame_err_o;
   logic       parity_err_o;
   logic       idle_o;

   int   checks_total = 0;
   int   checks_passed = 0;

   int   cyc = 0;
   int   t_start = 0;
   int   t_valid = 0;
   int   valid_cnt = 0;
   int   ferr_cnt = 0;
   int   perr_cnt = 0;
   int   dbl_cnt = 0;
   int   overlap_cnt = 0;
   logic prev_valid = 1'b0;
   logic prev_ferr = 1'b0;
   logic prev_perr = 1'b0;
   logic [7:0] rx_log [0:63];

   uart_rx #(.FCLK(50000000), .BAUD(115200)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n_i),
      .rx_i         (rx_i),
      .data_o       (data_o),
      .rx_valid_o   (rx_valid_o),
      .frame_err_o  (frame_err_o),
      .parity_err_o (parity_err_o),
      .idle_o       (idle_o)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: log received bytes, count flags, catch stretched or overlapping pulses.
   always @(negedge clk) begin
      if (rx_valid_o) begin
         if (valid_cnt < 64) rx_log[valid_cnt] = data_o;
         valid_cnt = valid_cnt + 1;
         t_valid   = cyc;
      end
      if (frame_err_o) ferr_cnt = ferr_cnt + 1;
      if (parity_err_o) perr_cnt = perr_cnt + 1;
      if ((rx_valid_o && prev_valid) || (frame_err_o && prev_ferr) || (parity_err_o && prev_perr))
         dbl_cnt = dbl_cnt + 1;
      if ((rx_valid_o && (frame_err_o || parity_err_o)) || (frame_err_o && parity_err_o))
         overlap_cnt = overlap_cnt + 1;
      prev_valid = rx_valid_o;
      prev_ferr  = frame_err_o;
      prev_perr  = parity_err_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total = checks_total + 1;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         checks_passed = checks_passed + 1;
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic line_bit(input logic b, input int n);
      rx_i = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop_b);
      t_start = cyc;
      line_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) line_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
      line_bit(par, CPB);
`endif
      line_bit(stop_b, CPB);
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, ^b, 1'b1);
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] b);
      int n0;
      n0 = valid_cnt;
      send_good(b);
      check({tag, "_valid_pulses"}, valid_cnt - n0, 1);
      check({tag, "_data"}, data_o, b);
      check({tag, "_idle"}, idle_o, 1'b1);
   endtask

   initial begin
      int n0;
      int f0;
      logic [7:0] bytes [3];
      bytes[0] = 8'hAA;
      bytes[1] = 8'h00;
      bytes[2] = 8'hFF;

      rst_n_i = 1'b0;
      rx_i    = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_data", data_o, 8'h00);
      check("rst_valid", rx_valid_o, 1'b0);
      check("rst_ferr", frame_err_o, 1'b0);
      check("rst_perr", parity_err_o, 1'b0);
      check("rst_idle", idle_o, 1'b1);
      rst_n_i = 1'b1;
      repeat (5) @(negedge clk);

      // 1: single frames, plus start-edge-to-valid latency on the first
      for (int i = 0; i < 3; i++) begin
         expect_byte($sformatf("t1_%02h", bytes[i]), bytes[i]);
         if (i == 0) check("t1_latency", t_valid - t_start, EXP_LAT);
      end
      repeat (20) @(negedge clk);

      // 2: back-to-back frames with no idle gap
      n0 = valid_cnt;
      send_good(8'h55);
      send_good(8'hA3);
      check("t2_pulses", valid_cnt - n0, 2);
      check("t2_first", rx_log[n0], 8'h55);
      check("t2_second", rx_log[n0 + 1], 8'hA3);
      repeat (20) @(negedge clk);

      // 3: 100 ns glitch is rejected at the start-bit centre
      n0 = valid_cnt;
      f0 = ferr_cnt;
      line_bit(1'b0, 5);
      line_bit(1'b1, 5);
      check("t3_busy", idle_o, 1'b0);
      repeat (CPB / 2 + 3 - 10) @(negedge clk);
      check("t3_idle", idle_o, 1'b1);
      check("t3_no_valid", valid_cnt - n0, 0);
      check("t3_no_ferr", ferr_cnt - f0, 0);

      // 4: bad stop bit, line held low, then recovery
      n0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'h3C, ^8'h3C, 1'b0);
      line_bit(1'b0, 2 * CPB);
      check("t4_ferr", ferr_cnt - f0, 1);
      check("t4_no_valid", valid_cnt - n0, 0);
      check("t4_data_kept", data_o, 8'hA3);
      check("t4_no_rearm", idle_o, 1'b0);
      line_bit(1'b1, 10);
      check("t4_idle_after_high", idle_o, 1'b1);
      expect_byte("t4_11", 8'h11);

      // 5: reset during bit 4 of 0xF0
      line_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) line_bit(1'(8'hF0 >> i), CPB);
      line_bit(1'b1, CPB / 2);
      check("t5_busy", idle_o, 1'b0);
      rst_n_i = 1'b0;
      @(negedge clk);
      check("t5_rst_data", data_o, 8'h00);
      check("t5_rst_valid", rx_valid_o, 1'b0);
      check("t5_rst_ferr", frame_err_o, 1'b0);
      check("t5_rst_idle", idle_o, 1'b1);
      rx_i = 1'b1;
      repeat (3) @(negedge clk);
      rst_n_i = 1'b1;
      repeat (10) @(negedge clk);
      expect_byte("t5_5a", 8'h5A);

`ifdef UART_RX_PARITY_EN
      // 6: parity mismatch then correct parity
      n0 = valid_cnt;
      f0 = perr_cnt;
      send_frame(8'h07, 1'b0, 1'b1);
      check("t6_perr", perr_cnt - f0, 1);
      check("t6_no_valid", valid_cnt - n0, 0);
      check("t6_data_kept", data_o, 8'h5A);
      send_frame(8'h07, 1'b1, 1'b1);
      check("t6_valid", valid_cnt - n0, 1);
      check("t6_data", data_o, 8'h07);
`else
      check("t6_perr_tied", perr_cnt, 0);
`endif

      check("pulse_width_one", dbl_cnt, 0);
      check("no_flag_overlap", overlap_cnt, 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
